// File: rtl/jpeg_enc_pkg.sv
// Shared definitions for the JPEG entropy-coded output path: accumulator sizing,
// stuffing constants and the packer control states.
package jpeg_enc_pkg;

  localparam int ACC_W_DEFAULT   = 32;
  localparam int MAX_LEN_DEFAULT = 16;

  localparam logic [7:0] JPEG_STUFF_TRIGGER = 8'hFF;
  localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } pack_state_t;

  // Fill the unused low bits of a partial byte with 1s; 'used' counts the
  // valid bits already present at the MSB end (0..8).
  function automatic logic [7:0] pad_byte(input logic [7:0] partial, input logic [3:0] used);
    return partial | (8'hFF >> used);
  endfunction

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Output byte register with JPEG 0xFF/0x00 stuffing. The accumulator offers a
// byte via has_byte/next_byte and learns it was consumed through take.
module jpeg_byte_stuffer
  import jpeg_enc_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       has_byte,
  input  logic [7:0] next_byte,
  output logic       take,
  output logic       reg_free,
  output logic       stuff_pending,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [7:0] byte_data
);

  // Handshake: a byte moves on every edge where byte_valid && byte_ready.
  // byte_valid/byte_data only change when the register is empty or that
  // handshake happens, so the data is held stable under backpressure.
  assign reg_free = !byte_valid || byte_ready;

  // A pending stuff byte has priority over fresh accumulator data.
  assign take = reg_free && !stuff_pending && has_byte;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_valid    <= 1'b0;
      byte_data     <= 8'h00;
      stuff_pending <= 1'b0;
    end else if (reg_free) begin
      if (stuff_pending) begin
        byte_valid    <= 1'b1;
        byte_data     <= JPEG_STUFF_BYTE;
        stuff_pending <= 1'b0;
      end else if (has_byte) begin
        byte_valid    <= 1'b1;
        byte_data     <= next_byte;
        stuff_pending <= (next_byte == JPEG_STUFF_TRIGGER);
      end else begin
        byte_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jpeg_bitstream_packer.sv
// Packs MSB-first variable-length codes into a stuffed JPEG byte stream and,
// on flush, pads the final partial byte with 1s before pulsing flush_done.
module jpeg_bitstream_packer
  import jpeg_enc_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEFAULT,
  parameter int MAX_LEN = MAX_LEN_DEFAULT
)(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        code_valid,
  output logic        code_ready,
  input  logic [15:0] code_data,
  input  logic [4:0]  code_len,
  input  logic        flush,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        flush_done,
  output logic        busy,
  output pack_state_t fsm_state
);

  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] BYTE_BITS   = CNT_W'(8);
  localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(ACC_W - MAX_LEN);
  localparam logic [CNT_W-1:0] ACC_BITS    = CNT_W'(ACC_W);

  pack_state_t      state, state_next;
  logic [ACC_W-1:0] acc, acc_next, acc_base, code_placed;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_base, top_shift;
  logic [15:0]      code_bits;
  logic             ready_en;
  logic             accept, has_byte, take, reg_free, stuff_pending, pad_now;

  // ready_en keeps code_ready low during the reset cycle itself.
  assign has_byte   = (cnt >= BYTE_BITS);
  assign code_ready = ready_en && (state == ST_RUN) && (cnt <= READY_LIMIT);
  assign accept     = code_valid && code_ready;
  assign pad_now    = (state == ST_FLUSH) && (cnt != '0) && (cnt < BYTE_BITS);

  // acc is left-aligned: the top cnt bits are valid, everything below is zero.
  // New code bits are placed right under the post-extraction valid region.
  always_comb begin
    code_bits   = code_data & ~(16'hFFFF << code_len);
    top_shift   = ACC_BITS - CNT_W'(code_len);
    acc_base    = take ? (acc << 8) : acc;
    cnt_base    = take ? (cnt - BYTE_BITS) : cnt;
    code_placed = (ACC_W'(code_bits) << top_shift) >> cnt_base;
    acc_next    = acc_base;
    cnt_next    = cnt_base;
    if (accept) begin
      acc_next = acc_base | code_placed;
      cnt_next = cnt_base + CNT_W'(code_len);
    end else if (pad_now) begin
      acc_next[ACC_W-1 -: 8] = pad_byte(acc[ACC_W-1 -: 8], cnt[3:0]);
      cnt_next               = BYTE_BITS;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (flush) state_next = ST_FLUSH;
      ST_FLUSH: if ((cnt == '0) && !stuff_pending && reg_free) state_next = ST_DONE;
      ST_DONE:  state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RUN;
      acc      <= '0;
      cnt      <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      cnt      <= cnt_next;
      ready_en <= 1'b1;
    end
  end

  jpeg_byte_stuffer u_stuffer (
    .clock         (clock),
    .reset_n       (reset_n),
    .has_byte      (has_byte),
    .next_byte     (acc[ACC_W-1 -: 8]),
    .take          (take),
    .reg_free      (reg_free),
    .stuff_pending (stuff_pending),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .byte_data     (byte_data)
  );

  assign flush_done = (state == ST_DONE);
  assign busy       = (state == ST_FLUSH) || (cnt != '0) || byte_valid;
  assign fsm_state  = state;

  cnt_bound: assert property (@(posedge clock) disable iff (!reset_n) cnt <= ACC_BITS);

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Directed and randomized bench for jpeg_bitstream_packer against a
// bit-queue reference model with JPEG byte stuffing.
module tb_jpeg_bitstream_packer;
  import jpeg_enc_pkg::*;

  // clock / reset
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        code_valid = 1'b0;
  logic        code_ready;
  logic [15:0] code_data = 16'h0;
  logic [4:0]  code_len = 5'd0;
  logic        flush = 1'b0;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic [7:0]  byte_data;
  logic        flush_done;
  logic        busy;
  pack_state_t fsm_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  jpeg_bitstream_packer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_data  (code_data),
    .code_len   (code_len),
    .flush      (flush),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .flush_done (flush_done),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // reference model: plain bit queue, bytes cut every 8 bits, 0x00 after 0xFF
  logic [7:0] exp_q[$];
  bit         model_bits[$];
  int         model_ff = 0;

  task automatic model_drain();
    logic [7:0] b;
    while (model_bits.size() >= 8) begin
      for (int i = 7; i >= 0; i--) b[i] = model_bits.pop_front();
      exp_q.push_back(b);
      if (b == 8'hFF) begin
        exp_q.push_back(8'h00);
        model_ff++;
      end
    end
  endtask

  task automatic model_code(input logic [15:0] d, input int l);
    for (int i = l - 1; i >= 0; i--) model_bits.push_back(d[i]);
    model_drain();
  endtask

  task automatic model_flush();
    while ((model_bits.size() % 8) != 0) model_bits.push_back(1'b1);
    model_drain();
  endtask

  // scoreboard / output monitor, sampled 1 time unit after the falling edge
  int         n_bytes = 0;
  int         last_hs_cyc = -1;
  int         rise_cyc = -1;
  bit         stalled = 0;
  bit         prev_valid = 0;
  logic [7:0] held_data = 8'h00;
  bit         rand_ready = 0;

  always @(negedge clock) begin
    #1;
    if (!reset_n) begin
      stalled    = 0;
      prev_valid = 0;
    end else begin
      if (stalled) begin
        check("hold_valid", 32'(byte_valid), 32'd1);
        check("hold_data", 32'(byte_data), 32'(held_data));
      end
      if (byte_valid && !prev_valid) rise_cyc = cyc;
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte_qsize", 32'(exp_q.size()), 32'd1);
        else check("byte", 32'(byte_data), 32'(exp_q.pop_front()));
        n_bytes++;
        last_hs_cyc = cyc;
      end
      stalled    = byte_valid && !byte_ready;
      held_data  = byte_data;
      prev_valid = byte_valid;
    end
  end

  always @(negedge clock) if (rand_ready) byte_ready = 1'($urandom_range(0, 1));

  // driver tasks: entered and left on a falling edge
  int last_acc_cyc = -1;

  task automatic send_code(input logic [15:0] d, input int l, input bit with_flush);
    int n = 0;
    logic [15:0] low_mask;
    low_mask   = 16'hFFFF >> (16 - l);
    code_valid = 1'b1;
    code_data  = (d & low_mask) | (16'($urandom) & ~low_mask);
    code_len   = 5'(l);
    flush      = with_flush;
    while (!code_ready && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (!code_ready) begin
      check("accept_timeout", 32'(code_ready), 32'd1);
      code_valid = 1'b0;
      flush      = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    last_acc_cyc = cyc;
    code_valid   = 1'b0;
    flush        = 1'b0;
    model_code(d, l);
    if (with_flush) model_flush();
  endtask

  task automatic wait_done(input string tag, input bit check_hs);
    int n = 0;
    while (!flush_done && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done_seen"}, 32'(flush_done), 32'd1);
    if (check_hs) check({tag, "_done_after_hs"}, 32'(cyc), 32'(last_hs_cyc + 1));
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    check({tag, "_done_pulse_len"}, 32'(flush_done), 32'd0);
  endtask

  task automatic do_flush(input string tag, input bit check_hs);
    flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    model_flush();
    wait_done(tag, check_hs);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, total_bits, b0, ff0, l, fcyc;
    logic [15:0] d;

    // reset state
    repeat (3) @(negedge clock);
    check("rst_code_ready", 32'(code_ready), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_data", 32'(byte_data), 32'h00);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_RUN));
    reset_n = 1'b1;
    check("rel_code_ready_before_edge", 32'(code_ready), 32'd0);
    @(negedge clock);
    check("rel_code_ready_after_edge", 32'(code_ready), 32'd1);

    // two nibbles form 0xAC, valid two cycles after the first accept
    rise_cyc = -1;
    send_code(16'hA, 4, 0);
    a1 = last_acc_cyc;
    send_code(16'hC, 4, 0);
    wait_drain("ac");
    check("ac_latency", 32'(rise_cyc - a1), 32'd2);

    // 0xFF stuffing with a 3-cycle stall mid-sequence
    send_code(16'h00FF, 8, 0);
    byte_ready = 1'b0;
    send_code(16'h0012, 8, 0);
    repeat (3) @(negedge clock);
    byte_ready = 1'b1;
    wait_drain("stuff_stall");

    // partial byte padded with 1s: 101 -> 0xBF
    send_code(16'h0005, 3, 0);
    do_flush("pad_bf", 1);
    // code and flush together: 0x7F/7 -> 0xFF, 0x00
    send_code(16'h007F, 7, 1);
    wait_done("pad_ff", 1);
    // flush with nothing buffered: DONE on the next cycle, no byte
    b0 = n_bytes;
    flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    fcyc = cyc;
    wait_done("empty_flush", 0);
    check("empty_flush_latency", 32'(last_hs_cyc < fcyc ? 1 : 0), 32'd1);
    check("empty_flush_bytes", 32'(n_bytes - b0), 32'd0);

    // backpressure: four 16-bit codes while the output is blocked
    byte_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_code(16'hABCD, 16, 0);
      end
      begin
        repeat (10) @(negedge clock);
        check("bp_code_ready_low", 32'(code_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        byte_ready = 1'b1;
      end
    join
    wait_drain("backpressure");

    // randomized lengths (including zero) under random output readiness
    total_bits = 0;
    b0 = n_bytes;
    ff0 = model_ff;
    rand_ready = 1;
    for (int i = 0; i < 60; i++) begin
      l = (i % 7 == 0) ? 0 : $urandom_range(1, 16);
      d = 16'($urandom);
      if (i % 11 == 3) d = 16'hFFFF;
      total_bits += l;
      send_code(d, l, 0);
    end
    rand_ready = 0;
    byte_ready = 1'b1;
    do_flush("random", 0);
    check("random_byte_count", 32'(n_bytes - b0), 32'((total_bits + 7) / 8 + (model_ff - ff0)));

    // asynchronous reset with 13 bits buffered and a byte held
    byte_ready = 1'b0;
    send_code(16'hABCD, 16, 0);
    send_code(16'h001F, 5, 0);
    repeat (3) @(negedge clock);
    check("pre_rst_valid", 32'(byte_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(byte_valid), 32'd0);
    check("async_rst_data", 32'(byte_data), 32'h00);
    check("async_rst_code_ready", 32'(code_ready), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    model_bits.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    byte_ready = 1'b1;
    @(negedge clock);
    check("post_rst_code_ready", 32'(code_ready), 32'd1);
    b0 = n_bytes;
    send_code(16'h00A5, 8, 0);
    do_flush("post_rst", 1);
    check("post_rst_byte_count", 32'(n_bytes - b0), 32'd1);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
